// File: rtl/alu_pkg.sv
// Shared constants, state encoding and helpers for the 16-bit alu datapath and its
// multiply/divide sequencer. ALU_MDSEQ_DIV_EN adds the divide states to the enum.
package alu_pkg;

  localparam int ALU_W = 16;

  // op_alu function select
  localparam logic [3:0] PASS  = 4'b0000;
  localparam logic [3:0] ADD   = 4'b1000;
  localparam logic [3:0] SUB   = 4'b0100;

  // op_shf shift select
  localparam logic [3:0] PASSC = 4'b0000;
  localparam logic [3:0] SHRC  = 4'b1101;
  localparam logic [3:0] SHLN  = 4'b1010;
  localparam logic [3:0] SHRN  = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
`ifdef ALU_MDSEQ_DIV_EN
    ST_DSHF,
    ST_DSUB,
`endif
    ST_DONE
  } mdseq_state_t;

  function automatic logic is_busy(mdseq_state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/alu_mdseq_if.sv
// Request/response bus of the multiply/divide sequencer: the master issues start/cmd
// with operands, the slave reports busy/done/err and the 32-bit result.
interface alu_mdseq_if;
  import alu_pkg::*;

  logic             start;
  logic             cmd;
  logic [ALU_W-1:0] opa;
  logic [ALU_W-1:0] oph;
  logic [ALU_W-1:0] opl;
  logic             busy;
  logic             done;
  logic             err;
  logic [ALU_W-1:0] res_hi;
  logic [ALU_W-1:0] res_lo;

  modport master (
    output start, cmd, opa, oph, opl,
    input  busy, done, err, res_hi, res_lo
  );

  modport slave (
    input  start, cmd, opa, oph, opl,
    output busy, done, err, res_hi, res_lo
  );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit alu: add/subtract/pass stage followed by a shifter; the
// sequencer steers both stages and consumes rshf, cf and the pre-shift bit 0.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]       op_alu,
  input  logic [3:0]       op_shf,
  input  logic [ALU_W-1:0] t,
  input  logic [ALU_W-1:0] aopy,
  input  logic             carry,
  input  logic             n15,
  input  logic             n0,
  output logic [ALU_W:0]   rshf,
  output logic             cf,
  output logic             arez0
);

  logic [ALU_W:0]   sum;
  logic [ALU_W-1:0] r;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    sum   = {1'b0, t};
    r     = '0;
    rshf  = '0;
    cf    = 1'b0;
    arez0 = 1'b0;

    unique case (op_alu)
      ADD:     sum = {1'b0, t} + {1'b0, aopy} + {{ALU_W{1'b0}}, carry};
      // carry-out set means no borrow, i.e. t >= aopy (carry acts as borrow-in)
      SUB:     sum = {1'b0, t} + {1'b0, ~aopy} + {{ALU_W{1'b0}}, ~carry};
      default: sum = {1'b0, t};
    endcase

    r     = sum[ALU_W-1:0];
    cf    = sum[ALU_W];
    arez0 = r[0];

    unique case (op_shf)
      SHRC:    rshf = {1'b0, cf, r[ALU_W-1:1]};
      SHLN:    rshf = {r, n15};
      SHRN:    rshf = {r[0], n0, r[ALU_W-1:1]};
      default: rshf = {cf, r};
    endcase
  end

endmodule

// File: rtl/alu_mdseq.sv
// Multi-cycle unsigned 16x16 shift-and-add multiply and 32/16 restoring divide around
// the external alu. Divide is present only when ALU_MDSEQ_DIV_EN is defined.
module alu_mdseq
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_mdseq_if.slave       bus,
  output logic [3:0]       op_alu,
  output logic [3:0]       op_shf,
  output logic [ALU_W-1:0] t,
  output logic [ALU_W-1:0] aopy,
  output logic             carry,
  output logic             n15,
  output logic             n0,
  input  logic [ALU_W:0]   rshf,
  input  logic             cf,
  input  logic             arez0
);

  mdseq_state_t     state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ALU_W-1:0] t_q, t_d;
  logic [ALU_W-1:0] n_q, n_d;
  logic [ALU_W-1:0] a_q, a_d;
  logic             err_q, err_d;
`ifdef ALU_MDSEQ_DIV_EN
  logic             ovb_q, ovb_d;
`else
  logic             unused_div;
  assign unused_div = &{1'b0, bus.oph, rshf[ALU_W], cf};
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      n_q     <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
`ifdef ALU_MDSEQ_DIV_EN
      ovb_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      n_q     <= n_d;
      a_q     <= a_d;
      err_q   <= err_d;
`ifdef ALU_MDSEQ_DIV_EN
      ovb_q   <= ovb_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    n_d     = n_q;
    a_d     = a_q;
    err_d   = err_q;
`ifdef ALU_MDSEQ_DIV_EN
    ovb_d   = ovb_q;
`endif
    op_alu  = PASS;
    op_shf  = PASSC;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d   = bus.opa;
          err_d = 1'b0;
          cnt_d = 4'd15;
          if (!bus.cmd) begin
            t_d     = '0;
            n_d     = bus.opl;
            state_d = ST_MUL;
          end else begin
`ifdef ALU_MDSEQ_DIV_EN
            // oph >= opa also rules out a quotient wider than 16 bits
            if ((bus.opa == '0) || (bus.oph >= bus.opa)) begin
              t_d     = '1;
              n_d     = '1;
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              t_d     = bus.oph;
              n_d     = bus.opl;
              state_d = ST_DSHF;
            end
`else
            t_d     = '1;
            n_d     = '1;
            err_d   = 1'b1;
            state_d = ST_DONE;
`endif
          end
        end
      end

      ST_MUL: begin
        op_alu = n_q[0] ? ADD : PASS;
        op_shf = SHRC;
        t_d    = rshf[ALU_W-1:0];
        n_d    = {arez0, n_q[ALU_W-1:1]};
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end

`ifdef ALU_MDSEQ_DIV_EN
      ST_DSHF: begin
        op_alu  = PASS;
        op_shf  = SHLN;
        t_d     = rshf[ALU_W-1:0];
        ovb_d   = rshf[ALU_W];
        n_d     = {n_q[ALU_W-2:0], 1'b0};
        state_d = ST_DSUB;
      end

      ST_DSUB: begin
        op_alu = SUB;
        op_shf = PASSC;
        // the bit shifted out of T makes the partial remainder exceed the divisor
        if (ovb_q | cf) begin
          t_d = rshf[ALU_W-1:0];
          n_d = {n_q[ALU_W-1:1], 1'b1};
        end
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_DSHF;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign t          = t_q;
  assign aopy       = a_q;
  assign carry      = 1'b0;
  assign n15        = n_q[ALU_W-1];
  assign n0         = n_q[0];

  assign bus.busy   = is_busy(state_q);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.err    = err_q;
  assign bus.res_hi = t_q;
  assign bus.res_lo = n_q;

endmodule

// File: tb/tb_alu_mdseq.sv
// Directed bench for alu_mdseq with the alu datapath beside it: multiply, divide,
// error responses, mid-operation reset and ignored start requests.
module tb_alu_mdseq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op_alu, op_shf;
  logic [15:0] t, aopy;
  logic        carry, n15, n0;
  logic [16:0] rshf;
  logic        cf, arez0;

  int vectors     = 0;
  int miscompares = 0;

  alu_mdseq_if bus ();

  alu_mdseq dut (
    .clk(clk), .rst(rst), .bus(bus),
    .op_alu(op_alu), .op_shf(op_shf), .t(t), .aopy(aopy),
    .carry(carry), .n15(n15), .n0(n0),
    .rshf(rshf), .cf(cf), .arez0(arez0)
  );

  alu u_alu (
    .op_alu(op_alu), .op_shf(op_shf), .t(t), .aopy(aopy),
    .carry(carry), .n15(n15), .n0(n0),
    .rshf(rshf), .cf(cf), .arez0(arez0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [77:0] all_outputs();
    return {bus.busy, bus.done, bus.err, bus.res_hi, bus.res_lo,
            op_alu, op_shf, t, aopy, carry, n15, n0};
  endfunction

  // Called at posedge+1 with the DUT idle; returns the cycles to done, the results,
  // and the done level one cycle later.
  task automatic run_op(input logic c, input logic [15:0] a, h, l,
                        output int lat, output logic [15:0] hi, lo,
                        output logic e, output logic done_after);
    bus.start = 1'b1; bus.cmd = c; bus.opa = a; bus.oph = h; bus.opl = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    hi = bus.res_hi; lo = bus.res_lo; e = bus.err;
    @(posedge clk); #1;
    done_after = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.cmd = 1'b0;
    bus.opa = '0; bus.oph = '0; bus.opl = '0;
    #3;
    vectors++;
    if (all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: busy/done/err got %b expected 000", {bus.busy, bus.done, bus.err});
    end
  endtask

  task automatic test_mul();
    logic [15:0] mt [3][4] = '{
      '{16'h1234, 16'h5678, 16'h0626, 16'h0060},
      '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001},
      '{16'h0000, 16'hABCD, 16'h0000, 16'h0000}};
    int lat; logic [15:0] hi, lo; logic e, da;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, mt[i][0], 16'hDEAD, mt[i][1], lat, hi, lo, e, da);
      vectors++;
      if ({hi, lo} !== {mt[i][2], mt[i][3]}) begin
        miscompares++;
        $display("FAIL mul%0d_result: got %h expected %h", i, {hi, lo}, {mt[i][2], mt[i][3]});
      end
      vectors++;
      if (lat !== 17) begin
        miscompares++;
        $display("FAIL mul%0d_latency: got %0d expected 17", i, lat);
      end
      vectors++;
      if ({e, da} !== 2'b00) begin
        miscompares++;
        $display("FAIL mul%0d_err_pulse: err,done_next got %b expected 00", i, {e, da});
      end
    end
  endtask

  task automatic test_div();
    logic [15:0] dt [4][5] = '{
      '{16'h0001, 16'h0000, 16'h0003, 16'h0001, 16'h5555},
      '{16'h0000, 16'h0064, 16'h0007, 16'h0002, 16'h000E},
      '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF},
      '{16'h0004, 16'hFFFF, 16'h0005, 16'h0004, 16'hFFFF}};
    int lat, exp_lat; logic [15:0] hi, lo; logic e, da, exp_err;
    logic [31:0] exp_res;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_MDSEQ_DIV_EN
      exp_lat = 33; exp_err = 1'b0; exp_res = {dt[i][3], dt[i][4]};
`else
      exp_lat = 1;  exp_err = 1'b1; exp_res = 32'hFFFF_FFFF;
`endif
      run_op(1'b1, dt[i][2], dt[i][0], dt[i][1], lat, hi, lo, e, da);
      vectors++;
      if ({hi, lo} !== exp_res) begin
        miscompares++;
        $display("FAIL div%0d_result: got %h expected %h", i, {hi, lo}, exp_res);
      end
      vectors++;
      if (lat !== exp_lat) begin
        miscompares++;
        $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, exp_lat);
      end
      vectors++;
      if ({e, da} !== {exp_err, 1'b0}) begin
        miscompares++;
        $display("FAIL div%0d_err_pulse: err,done_next got %b expected %b", i, {e, da}, {exp_err, 1'b0});
      end
    end
  endtask

  task automatic test_div_err();
    logic [15:0] et [2][3] = '{
      '{16'h1234, 16'h5678, 16'h0000},
      '{16'h0005, 16'h0000, 16'h0005}};
    int lat; logic [15:0] hi, lo; logic e, da;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, et[i][2], et[i][0], et[i][1], lat, hi, lo, e, da);
      vectors++;
      if ({e, hi, lo} !== {1'b1, 32'hFFFF_FFFF}) begin
        miscompares++;
        $display("FAIL diverr%0d_result: err,result got %h expected 1ffffffff", i, {e, hi, lo});
      end
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("FAIL diverr%0d_latency: got %0d expected 1", i, lat);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.err, bus.res_hi, bus.res_lo} !== {2'b01, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL diverr_hold: busy,err,result got %h expected 1ffffffff",
               {bus.busy, bus.err, bus.res_hi, bus.res_lo});
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] hi, lo; logic e, da, saw_done;
    bus.start = 1'b1; bus.cmd = 1'b0; bus.opa = 16'h1234; bus.opl = 16'h5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy: got %b expected 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got %h expected 0", all_outputs());
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_no_done: activity got %b expected 0", saw_done);
    end
    run_op(1'b0, 16'h8000, 16'h0000, 16'h0003, lat, hi, lo, e, da);
    vectors++;
    if ({lat == 17, e, hi, lo} !== {2'b10, 32'h0001_8000}) begin
      miscompares++;
      $display("FAIL rstmid_rerun: lat=%0d err=%b result got %h expected lat 17 err 0 %h",
               lat, e, {hi, lo}, 32'h0001_8000);
    end
  endtask

  task automatic test_ignore_start();
    int lat; logic bad_busy, extra_done;
    bad_busy = 1'b0;
    bus.start = 1'b1; bus.cmd = 1'b0; bus.opa = 16'h0003; bus.oph = 16'h0000; bus.opl = 16'h0005;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (lat == 5) begin
        if (bus.busy !== 1'b1) bad_busy = 1'b1;
        bus.start = 1'b1; bus.cmd = 1'b1; bus.opa = 16'h0000; bus.opl = 16'hFFFF;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (bad_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_busy_mid: busy low mid-operation got 1 expected 0");
    end
    vectors++;
    if ({lat == 17, bus.busy, bus.err, bus.res_hi, bus.res_lo} !== {3'b100, 32'h0000_000F}) begin
      miscompares++;
      $display("FAIL ignore_result: lat=%0d busy=%b err=%b result got %h expected lat 17 busy 0 err 0 0000000f",
               lat, bus.busy, bus.err, {bus.res_hi, bus.res_lo});
    end
    bus.start = 1'b1; bus.cmd = 1'b1; bus.opa = 16'h0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    extra_done = 1'b0;
    repeat (4) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra_done = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if ({extra_done, bus.err, bus.res_lo} !== {2'b00, 16'h000F}) begin
      miscompares++;
      $display("FAIL ignore_done_cycle: activity,err,res_lo got %h expected 0000f",
               {extra_done, bus.err, bus.res_lo});
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_err();
    test_ignore_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
